note_player: RTL and testbench
==============================

# note_player

Downstream stage of `song_reader` in the music player. It latches each note/duration pair issued by `song_reader`, counts the note's duration in beats, and advances a phase accumulator once per audio sample. The accumulator output drives the sine lookup. When the duration expires it returns a one-cycle `note_done` pulse, which makes `song_reader` fetch the next note.

## Interface
Parameters:
- PHASE_W, 22, phase accumulator width; its top bits address the sine ROM
- STEP_W, 20, step-size width returned by the frequency ROM

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- play  input  1  1 = playing, 0 = paused (freeze)
- ff  input  1  fast-forward: consume 2 beats of duration per beat pulse
- note  input  6  note index from `song_reader`; 0 = rest
- duration  input  6  note length in beats
- load_new_note  input  1  one-cycle strobe; latch `note` and `duration`
- beat  input  1  one-cycle beat tick (48 Hz)
- generate_next_sample  input  1  one-cycle sample request from the codec
- step_size  input  STEP_W  frequency ROM data for `rom_note`; combinational, same cycle
- rom_note  output  6  latched note, used as the frequency ROM address
- phase  output  PHASE_W  current phase accumulator value
- mute  output  1  1 when the output sample must be silent
- sample_ready  output  1  one-cycle pulse; `phase`/`mute` are valid for the new sample
- note_done  output  1  one-cycle pulse; current note finished
- busy  output  1  1 in the PLAYING state

## Operation
- States:
  - IDLE: no note.
  - PLAYING: note active.
  - DONE: single cycle that drives `note_done`; always returns to IDLE.
- Reset (reset=0, asynchronous): state IDLE. `rom_note`, `phase`, `sample_ready`, `note_done`, `busy` = 0. Internal remaining-beats counter = 0. `mute` = 1.
- `load_new_note` in any state:
  - Latch `note` into `rom_note`, `duration` into remaining, clear `phase`.
  - Go to PLAYING, or to DONE if `duration` = 0.
  - Load has priority over a `beat` or sample request in the same cycle; that beat and that sample request are discarded.
  - A load during PLAYING aborts the current note silently (no `note_done` for it).
- PLAYING with play=1 and `beat`:
  - remaining <= remaining − (ff ? 2 : 1), saturating at 0.
  - When the result is 0, go to DONE.
- PLAYING with play=0: `beat` is ignored, remaining is frozen, and `phase` is frozen.
- Sample path:
  - On `generate_next_sample`, if PLAYING && play && rom_note≠0: phase <= phase + zero-extended `step_size`, wrapping modulo 2^PHASE_W.
  - In all other cases `phase` holds.
  - `sample_ready` pulses on every `generate_next_sample` in every state, except one discarded by a simultaneous load.
- `mute` = 1 unless state is PLAYING, play=1, and rom_note≠0.
- `rom_note` keeps its value after DONE until the next load.

## Timing
- All outputs are registered, except `mute` and `busy`, which decode registered state.
- Load latency: `load_new_note` at edge N gives `busy`=1 and the new `rom_note` from edge N onward; the first sample is accepted at edge N+1.
- `sample_ready` is high during the cycle after the `generate_next_sample` edge, with the updated `phase`.
- `note_done` is high during the cycle after the edge on which remaining reached 0; it is exactly one cycle wide.
- Beat and sample requests arriving in DONE or IDLE do not change remaining.

## Test plan
- Normal note: load note=20, duration=3, play=1, ff=0, then 3 beats. Required: `note_done` is a single pulse one cycle after the 3rd beat edge; `busy` drops with it; state IDLE.
- Fast-forward: load duration=3, ff=1. Required: remaining goes 3→1→0, and `note_done` follows the 2nd beat. With duration=1 and ff=1, the 1st beat saturates remaining to 0.
- Pause: play=0 during PLAYING with remaining=2, issue 5 beats and 5 sample requests. Required: remaining stays 2, `phase` is unchanged, `mute`=1, 5 `sample_ready` pulses, no `note_done`.
- Phase wrap: load note=5 with step_size=0x80000, phase preset by 8 requests to 0x0. Required: after 7 requests `phase`=0x380000; after the next 1, `phase`=0x0 (modulo 2^22).
- Rest and zero duration: note=0, duration=2 gives `mute`=1, `phase` held at 0, `note_done` after 2 beats. duration=0 gives `note_done` one cycle after the load.
- Overrides:
  - A load mid-note (remaining=4) produces no `note_done` for the old note and restarts with the new duration.
  - Load and `beat` in the same cycle leave remaining = new duration.
  - reset=0 mid-note immediately clears all outputs; `mute`=1.

Source files
------------

// File: rtl/note_player_if.sv
// Note hand-off between song_reader and note_player: the reader issues a
// note/duration pair with a load strobe, and the player answers with note_done.
interface note_player_if;
  logic [5:0] note;
  logic [5:0] duration;
  logic       load_new_note;
  logic       note_done;

  modport master (output note, output duration, output load_new_note, input note_done);
  modport slave  (input note, input duration, input load_new_note, output note_done);
endinterface

// File: rtl/note_player.sv
// Plays one note at a time: counts its duration in beats, advances the sine
// phase accumulator per audio sample, and pulses note_done when the note ends.
module note_player #(
  parameter int PHASE_W = 22,
  parameter int STEP_W  = 20
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               play,
  input  logic               ff,
  input  logic               beat,
  input  logic               generate_next_sample,
  input  logic [STEP_W-1:0]  step_size,
  note_player_if.slave       song,
  output logic [5:0]         rom_note,
  output logic [PHASE_W-1:0] phase,
  output logic               mute,
  output logic               sample_ready,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, PLAYING, DONE} state_t;

  state_t             state, state_next;
  logic [5:0]         remaining, remaining_next;
  logic [5:0]         rom_note_next;
  logic [PHASE_W-1:0] phase_next;
  logic               sample_ready_next;
  logic               note_done_q;
  logic               sounding;
  logic [5:0]         beat_dec;
  logic [PHASE_W-1:0] step_ext;

  assign sounding     = (state == PLAYING) && play && (rom_note != 6'd0);
  assign mute         = !sounding;
  assign busy         = (state == PLAYING);
  assign beat_dec     = ff ? 6'd2 : 6'd1;
  assign step_ext     = {{(PHASE_W-STEP_W){1'b0}}, step_size};
  assign song.note_done = note_done_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      remaining    <= 6'd0;
      rom_note     <= 6'd0;
      phase        <= '0;
      sample_ready <= 1'b0;
      note_done_q  <= 1'b0;
    end else begin
      state        <= state_next;
      remaining    <= remaining_next;
      rom_note     <= rom_note_next;
      phase        <= phase_next;
      sample_ready <= sample_ready_next;
      note_done_q  <= (state_next == DONE);
    end
  end

  // A load wins over everything else in its cycle; the beat and sample
  // request that coincide with it are dropped, and an active note is
  // abandoned without a note_done.
  always_comb begin
    state_next        = state;
    remaining_next    = remaining;
    rom_note_next     = rom_note;
    phase_next        = phase;
    sample_ready_next = 1'b0;

    if (song.load_new_note) begin
      rom_note_next  = song.note;
      remaining_next = song.duration;
      phase_next     = '0;
      state_next     = (song.duration == 6'd0) ? DONE : PLAYING;
    end else begin
      sample_ready_next = generate_next_sample;
      if (generate_next_sample && sounding) begin
        phase_next = phase + step_ext;
      end
      case (state)
        IDLE: state_next = IDLE;
        PLAYING: begin
          // Saturating countdown so fast-forward never underflows.
          if (play && beat) begin
            if (remaining <= beat_dec) begin
              remaining_next = 6'd0;
              state_next     = DONE;
            end else begin
              remaining_next = remaining - beat_dec;
            end
          end
        end
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_note_player.sv
// Directed-vector bench for note_player with hand-computed expectations.
module tb_note_player;
  localparam int PHASE_W = 22;
  localparam int STEP_W  = 20;

  logic               clk = 1'b0;
  logic               reset;
  logic               play;
  logic               ff;
  logic               beat;
  logic               generate_next_sample;
  logic [STEP_W-1:0]  step_size;
  logic [5:0]         rom_note;
  logic [PHASE_W-1:0] phase;
  logic               mute;
  logic               sample_ready;
  logic               busy;

  int check_count = 0;
  int fail_count  = 0;

  note_player_if song_bus();

  note_player #(.PHASE_W(PHASE_W), .STEP_W(STEP_W)) dut (
    .clk                  (clk),
    .reset                (reset),
    .play                 (play),
    .ff                   (ff),
    .beat                 (beat),
    .generate_next_sample (generate_next_sample),
    .step_size            (step_size),
    .song                 (song_bus.slave),
    .rom_note             (rom_note),
    .phase                (phase),
    .mute                 (mute),
    .sample_ready         (sample_ready),
    .busy                 (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Drives one cycle of strobes, then returns 1 time unit after the edge.
  task automatic applyStimulus(input logic load, input logic [5:0] n, input logic [5:0] d,
                               input logic bt, input logic gen);
    song_bus.load_new_note = load;
    song_bus.note          = n;
    song_bus.duration      = d;
    beat                   = bt;
    generate_next_sample   = gen;
    @(posedge clk);
    #1;
    song_bus.load_new_note = 1'b0;
    beat                   = 1'b0;
    generate_next_sample   = 1'b0;
  endtask

  task automatic loadNote(input logic [5:0] n, input logic [5:0] d);
    applyStimulus(1'b1, n, d, 1'b0, 1'b0);
  endtask

  task automatic beatPulse();
    applyStimulus(1'b0, 6'd0, 6'd0, 1'b1, 1'b0);
  endtask

  task automatic samplePulse();
    applyStimulus(1'b0, 6'd0, 6'd0, 1'b0, 1'b1);
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 6'd0, 6'd0, 1'b0, 1'b0);
  endtask

  initial begin
    int sr_count;
    int nd_count;

    reset                  = 1'b0;
    play                   = 1'b1;
    ff                     = 1'b0;
    beat                   = 1'b0;
    generate_next_sample   = 1'b0;
    step_size              = 20'h01000;
    song_bus.note          = 6'd0;
    song_bus.duration      = 6'd0;
    song_bus.load_new_note = 1'b0;

    #12;
    checkOutput("reset rom_note", 32'(rom_note), 32'd0);
    checkOutput("reset phase", 32'(phase), 32'd0);
    checkOutput("reset mute", 32'(mute), 32'd1);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset note_done", 32'(song_bus.note_done), 32'd0);
    checkOutput("reset sample_ready", 32'(sample_ready), 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Normal note
    loadNote(6'd20, 6'd3);
    checkOutput("load busy", 32'(busy), 32'd1);
    checkOutput("load rom_note", 32'(rom_note), 32'd20);
    checkOutput("load mute", 32'(mute), 32'd0);
    samplePulse();
    checkOutput("play phase", 32'(phase), 32'h1000);
    checkOutput("play sample_ready", 32'(sample_ready), 32'd1);
    idleCycle();
    checkOutput("sample_ready width", 32'(sample_ready), 32'd0);
    beatPulse();
    beatPulse();
    checkOutput("normal beat2 note_done", 32'(song_bus.note_done), 32'd0);
    checkOutput("normal beat2 busy", 32'(busy), 32'd1);
    beatPulse();
    checkOutput("normal beat3 note_done", 32'(song_bus.note_done), 32'd1);
    checkOutput("normal beat3 busy", 32'(busy), 32'd0);
    checkOutput("normal done mute", 32'(mute), 32'd1);
    idleCycle();
    checkOutput("normal note_done width", 32'(song_bus.note_done), 32'd0);
    checkOutput("rom_note kept after done", 32'(rom_note), 32'd20);
    samplePulse();
    checkOutput("idle sample_ready", 32'(sample_ready), 32'd1);
    checkOutput("idle phase held", 32'(phase), 32'h1000);

    // Fast-forward
    ff = 1'b1;
    loadNote(6'd20, 6'd3);
    beatPulse();
    checkOutput("ff beat1 note_done", 32'(song_bus.note_done), 32'd0);
    beatPulse();
    checkOutput("ff beat2 note_done", 32'(song_bus.note_done), 32'd1);
    loadNote(6'd20, 6'd1);
    beatPulse();
    checkOutput("ff saturate note_done", 32'(song_bus.note_done), 32'd1);
    ff = 1'b0;

    // Pause with remaining = 2
    loadNote(6'd20, 6'd4);
    beatPulse();
    beatPulse();
    samplePulse();
    play = 1'b0;
    #1;
    checkOutput("pause mute", 32'(mute), 32'd1);
    sr_count = 0;
    nd_count = 0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 6'd0, 6'd0, 1'b1, 1'b1);
      sr_count += int'(sample_ready);
      nd_count += int'(song_bus.note_done);
    end
    checkOutput("pause sample_ready pulses", 32'(sr_count), 32'd5);
    checkOutput("pause note_done pulses", 32'(nd_count), 32'd0);
    checkOutput("pause phase frozen", 32'(phase), 32'h1000);
    play = 1'b1;
    beatPulse();
    checkOutput("resume beat1 note_done", 32'(song_bus.note_done), 32'd0);
    beatPulse();
    checkOutput("resume beat2 note_done", 32'(song_bus.note_done), 32'd1);

    // Phase wrap
    step_size = 20'h80000;
    loadNote(6'd5, 6'd10);
    for (int i = 1; i <= 8; i++) begin
      samplePulse();
      if (i == 7) checkOutput("wrap phase after 7", 32'(phase), 32'h380000);
      if (i == 8) checkOutput("wrap phase after 8", 32'(phase), 32'h0);
    end

    // Rest and zero duration
    loadNote(6'd0, 6'd2);
    checkOutput("rest mute", 32'(mute), 32'd1);
    samplePulse();
    checkOutput("rest phase held", 32'(phase), 32'h0);
    checkOutput("rest sample_ready", 32'(sample_ready), 32'd1);
    beatPulse();
    checkOutput("rest beat1 note_done", 32'(song_bus.note_done), 32'd0);
    beatPulse();
    checkOutput("rest beat2 note_done", 32'(song_bus.note_done), 32'd1);
    loadNote(6'd9, 6'd0);
    checkOutput("zero dur note_done", 32'(song_bus.note_done), 32'd1);
    checkOutput("zero dur busy", 32'(busy), 32'd0);
    idleCycle();
    checkOutput("zero dur note_done width", 32'(song_bus.note_done), 32'd0);

    // Mid-note load aborts silently and restarts with the new duration
    loadNote(6'd20, 6'd6);
    beatPulse();
    beatPulse();
    loadNote(6'd21, 6'd2);
    checkOutput("abort note_done", 32'(song_bus.note_done), 32'd0);
    checkOutput("abort rom_note", 32'(rom_note), 32'd21);
    beatPulse();
    checkOutput("abort beat1 note_done", 32'(song_bus.note_done), 32'd0);
    beatPulse();
    checkOutput("abort beat2 note_done", 32'(song_bus.note_done), 32'd1);

    // Load and beat together: beat discarded
    applyStimulus(1'b1, 6'd20, 6'd3, 1'b1, 1'b1);
    checkOutput("load+beat sample_ready", 32'(sample_ready), 32'd0);
    beatPulse();
    beatPulse();
    checkOutput("load+beat beat2 note_done", 32'(song_bus.note_done), 32'd0);
    beatPulse();
    checkOutput("load+beat beat3 note_done", 32'(song_bus.note_done), 32'd1);

    // Asynchronous reset mid-note
    step_size = 20'h01000;
    loadNote(6'd7, 6'd5);
    samplePulse();
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async reset phase", 32'(phase), 32'd0);
    checkOutput("async reset rom_note", 32'(rom_note), 32'd0);
    checkOutput("async reset busy", 32'(busy), 32'd0);
    checkOutput("async reset mute", 32'(mute), 32'd1);
    checkOutput("async reset sample_ready", 32'(sample_ready), 32'd0);
    reset = 1'b1;
    idleCycle();

    $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
    $finish;
  end

endmodule
